// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg
//   Shared types and helpers for the cnn run checker and its compare helper.
//   - state_e : run-controller states
//   - elem_t  : default-width signed feature-map element
//   - addr_w  : address width for n elements, never narrower than 1 bit
// ----------------------------------------------------------------------------
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Default element width; modules carry their own DATA_W_p parameter.
    localparam int ELEM_W = 16;
    typedef logic signed [ELEM_W-1:0] elem_t;

    function automatic int addr_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            addr_w = 1;
        end else begin
            addr_w = w;
        end
    endfunction

endpackage : cnn_pkg

// File: rtl/cnn_abs_diff_cmp.sv
// ----------------------------------------------------------------------------
// cnn_abs_diff_cmp
//   Combinational tolerance compare of two signed elements.
//   Both operands are sign-extended by one bit before subtracting so that the
//   difference of extreme values (e.g. 0x7FFF vs 0x8000) cannot wrap.
// Ports
//   a_i        in  DATA_W_p  signed element (DUT side)
//   b_i        in  DATA_W_p  signed element (golden side)
//   mismatch_o out 1         |a_i - b_i| > TOL_p
// ----------------------------------------------------------------------------
module cnn_abs_diff_cmp
    import cnn_pkg::*;
#(
    parameter int DATA_W_p = 16,
    parameter int TOL_p    = 0
) (
    input  logic signed [DATA_W_p-1:0] a_i,
    input  logic signed [DATA_W_p-1:0] b_i,
    output logic                       mismatch_o
);

    localparam logic [DATA_W_p:0] TOL_EXT = (DATA_W_p + 1)'(TOL_p);

    logic signed [DATA_W_p:0] a_ext_s;
    logic signed [DATA_W_p:0] b_ext_s;
    logic signed [DATA_W_p:0] diff_s;
    logic        [DATA_W_p:0] abs_s;

    // Widen, subtract, take magnitude and compare against the tolerance.
    always_comb begin
        a_ext_s = {a_i[DATA_W_p-1], a_i};
        b_ext_s = {b_i[DATA_W_p-1], b_i};
        diff_s  = a_ext_s - b_ext_s;
        if (diff_s[DATA_W_p]) begin
            abs_s = $unsigned(-diff_s);
        end else begin
            abs_s = $unsigned(diff_s);
        end
        mismatch_o = (abs_s > TOL_EXT);
    end

endmodule : cnn_abs_diff_cmp

// File: rtl/cnn_run_checker.sv
// ----------------------------------------------------------------------------
// cnn_run_checker
//   Launches one cnn core run, waits for its done (with timeout), scans every
//   output element against golden memory and reports pass/fail, a saturating
//   mismatch count and the first failing address.
// Ports
//   clk_i, reset_n_i         clock, async active-low reset
//   start_i                  run request, honoured only in IDLE/DONE
//   dut_valid_o              one-cycle launch pulse to the core
//   dut_done_i               core finished, looked at only while waiting
//   rd_en_o, rd_addr_o       read strobe/address to DUT and golden memories
//   dut_data_i, gold_data_i  returned elements, one cycle after rd_en_o
//   busy_o, done_o           run in progress / results valid
//   pass_o, timeout_o        verdict flags, valid in DONE
//   err_count_o              mismatches this run (saturating)
//   first_err_addr_o         address of first mismatch, 0 if none
// ----------------------------------------------------------------------------
module cnn_run_checker
    import cnn_pkg::*;
#(
    parameter  int M_p       = 1,
    parameter  int R_p       = 4,
    parameter  int C_p       = 4,
    parameter  int DATA_W_p  = 16,
    parameter  int TOL_p     = 0,
    parameter  int TIMEOUT_p = 300,
    parameter  int ERR_W_p   = 16,
    localparam int ADDR_W    = addr_w(M_p * R_p * C_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    output logic                       dut_valid_o,
    input  logic                       dut_done_i,
    output logic                       rd_en_o,
    output logic [ADDR_W-1:0]          rd_addr_o,
    input  logic signed [DATA_W_p-1:0] dut_data_i,
    input  logic signed [DATA_W_p-1:0] gold_data_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic                       timeout_o,
    output logic [ERR_W_p-1:0]         err_count_o,
    output logic [ADDR_W-1:0]          first_err_addr_o
);

    localparam int                 N_ELEM    = M_p * R_p * C_p;
    localparam int                 WCNT_W    = addr_w(TIMEOUT_p + 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_ELEM - 1);
    localparam logic [WCNT_W-1:0]  WAIT_LAST = WCNT_W'(TIMEOUT_p - 1);

    state_e              state_q,     state_d;
    logic [WCNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic                rd_en_q,     rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
    logic                cmp_en_q,    cmp_en_d;
    logic [ADDR_W-1:0]   cmp_addr_q,  cmp_addr_d;
    logic                dut_valid_q, dut_valid_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                pass_q,      pass_d;
    logic                timeout_q,   timeout_d;
    logic [ERR_W_p-1:0]  err_cnt_q,   err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic                mismatch_s;
    logic                accept_s;

    cnn_abs_diff_cmp #(
        .DATA_W_p (DATA_W_p),
        .TOL_p    (TOL_p)
    ) u_cmp (
        .a_i        (dut_data_i),
        .b_i        (gold_data_i),
        .mismatch_o (mismatch_s)
    );

    // Next-state logic of the run controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_LAUNCH;
                else         state_d = ST_IDLE;
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                // done has priority over an expiry in the same cycle
                if (dut_done_i)                    state_d = ST_SCAN;
                else if (wait_cnt_q == WAIT_LAST)  state_d = ST_DONE;
                else                               state_d = ST_WAIT;
            end
            ST_SCAN: begin
                if (rd_addr_q == LAST_ADDR) state_d = ST_FLUSH;
                else                        state_d = ST_SCAN;
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE: begin
                if (start_i) state_d = ST_LAUNCH;
                else         state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, read port, compare alignment and result bookkeeping.
    always_comb begin
        accept_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i;

        if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        else                    wait_cnt_d = '0;

        rd_en_d = (state_d == ST_SCAN);
        if ((state_d == ST_SCAN) && (state_q == ST_SCAN)) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end else begin
            rd_addr_d = '0;
        end

        // Memory data returns one cycle after the strobe; delay strobe/addr to match.
        cmp_en_d   = rd_en_q;
        cmp_addr_d = rd_addr_q;

        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        timeout_d   = timeout_q;
        if (accept_s) begin
            err_cnt_d   = '0;
            first_err_d = '0;
            timeout_d   = 1'b0;
        end else begin
            if (cmp_en_q && mismatch_s) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W_p'(1);
                else                 err_cnt_d = err_cnt_q;
                if (err_cnt_q == '0) first_err_d = cmp_addr_q;
                else                 first_err_d = first_err_q;
            end else begin
                err_cnt_d   = err_cnt_q;
                first_err_d = first_err_q;
            end
            if ((state_q == ST_WAIT) && (state_d == ST_DONE)) timeout_d = 1'b1;
            else                                              timeout_d = timeout_q;
        end

        dut_valid_d = (state_d == ST_LAUNCH);
        busy_d      = (state_d == ST_LAUNCH) || (state_d == ST_WAIT) ||
                      (state_d == ST_SCAN)   || (state_d == ST_FLUSH);
        done_d      = (state_d == ST_DONE);
        // The last compare lands on the same edge that enters DONE, so judge on the _d values.
        pass_d      = (state_d == ST_DONE) && !timeout_d && (err_cnt_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            cmp_en_q    <= 1'b0;
            cmp_addr_q  <= '0;
            dut_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            cmp_en_q    <= cmp_en_d;
            cmp_addr_q  <= cmp_addr_d;
            dut_valid_q <= dut_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign dut_valid_o      = dut_valid_q;
    assign rd_en_o          = rd_en_q;
    assign rd_addr_o        = rd_addr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = timeout_q;
    assign err_count_o      = err_cnt_q;
    assign first_err_addr_o = first_err_q;

endmodule : cnn_run_checker

// File: tb/tb_cnn_run_checker.sv
// ----------------------------------------------------------------------------
// tb_cnn_run_checker
//   Two checker instances (TOL 0 and TOL 2, TIMEOUT 10) share one stimulus
//   stream and each reads its own copy of the DUT/golden memories.
// ----------------------------------------------------------------------------
module tb_cnn_run_checker;

    localparam int N = 16;
    localparam int T = 10;

    logic clk = 1'b0;
    logic reset_n_i;
    logic start_i;
    logic dut_done_i;

    logic        a_dut_valid, a_rd_en, a_busy, a_done, a_pass, a_timeout;
    logic [3:0]  a_rd_addr, a_first;
    logic [15:0] a_err;
    logic signed [15:0] a_dut_data, a_gold_data;

    logic        b_dut_valid, b_rd_en, b_busy, b_done, b_pass, b_timeout;
    logic [3:0]  b_rd_addr, b_first;
    logic [15:0] b_err;
    logic signed [15:0] b_dut_data, b_gold_data;

    logic signed [15:0] dmem [N];
    logic signed [15:0] gmem [N];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int d; int mode; int lat; int to;
        int err_a; int first_a; int err_b; int first_b;
        int pass_a; int pass_b; int rd;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_rd_en) begin
            a_dut_data  <= dmem[a_rd_addr];
            a_gold_data <= gmem[a_rd_addr];
        end
        if (b_rd_en) begin
            b_dut_data  <= dmem[b_rd_addr];
            b_gold_data <= gmem[b_rd_addr];
        end
    end

    cnn_run_checker #(.TOL_p(0), .TIMEOUT_p(T)) u_dut_a (
        .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
        .dut_valid_o(a_dut_valid), .dut_done_i(dut_done_i),
        .rd_en_o(a_rd_en), .rd_addr_o(a_rd_addr),
        .dut_data_i(a_dut_data), .gold_data_i(a_gold_data),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .timeout_o(a_timeout),
        .err_count_o(a_err), .first_err_addr_o(a_first)
    );

    cnn_run_checker #(.TOL_p(2), .TIMEOUT_p(T)) u_dut_b (
        .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
        .dut_valid_o(b_dut_valid), .dut_done_i(dut_done_i),
        .rd_en_o(b_rd_en), .rd_addr_o(b_rd_addr),
        .dut_data_i(b_dut_data), .gold_data_i(b_gold_data),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_timeout),
        .err_count_o(b_err), .first_err_addr_o(b_first)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_mode(input int mode);
        for (int i = 0; i < N; i++) begin
            gmem[i] = 16'(i * 37 - 300);
            dmem[i] = gmem[i];
        end
        if (mode == 1) begin
            dmem[5]  = gmem[5]  + 16'sd3;
            dmem[11] = gmem[11] + 16'sd3;
        end else if (mode == 2) begin
            for (int i = 0; i < N; i++) dmem[i] = gmem[i] + 16'sd2;
            gmem[3] = 16'sh7FFD; dmem[3] = 16'sh7FFF;
            gmem[7] = 16'sh7FFF; dmem[7] = 16'sh8000;
        end
    endtask

    // Reference: count elements whose true magnitude difference exceeds tol.
    task automatic model(input int tol, output int err, output int first);
        int dv, gv, diff;
        err = 0; first = 0;
        for (int i = 0; i < N; i++) begin
            dv = dmem[i]; gv = gmem[i];
            diff = dv - gv;
            if (diff < 0) diff = -diff;
            if (diff > tol) begin
                if (err == 0) first = i;
                err++;
            end
        end
    endtask

    // d: WAIT cycle in which dut_done_i is first seen (0 = never).
    // extra: edge index after which a second start_i is offered while busy (-1 = none).
    task automatic run_check(input string tag, input int d, input int extra,
                             input int e_lat, input int e_to,
                             input int e_err_a, input int e_first_a,
                             input int e_err_b, input int e_first_b,
                             input int e_pass_a, input int e_pass_b, input int e_rd);
        int n, va, vb, rd;
        bit got;
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        n = 0; va = 0; vb = 0; rd = 0; got = 1'b0;
        while (!got && n < 200) begin
            if (a_dut_valid) va++;
            if (b_dut_valid) vb++;
            if (a_rd_en || b_rd_en) rd = 1;
            if (a_done) begin
                got = 1'b1;
            end else begin
                start_i = (n == extra);
                if (d != 0 && n == d) dut_done_i = 1'b1;
                @(posedge clk); #1; n++;
            end
        end
        start_i = 1'b0; dut_done_i = 1'b0;
        chk({tag, " done_reached"}, int'(got), 1);
        chk({tag, " latency"}, n, e_lat);
        chk({tag, " b_done"}, int'(b_done), 1);
        chk({tag, " busy_in_done"}, int'(a_busy), 0);
        chk({tag, " timeout_a"}, int'(a_timeout), e_to);
        chk({tag, " timeout_b"}, int'(b_timeout), e_to);
        chk({tag, " err_a"}, int'(a_err), e_err_a);
        chk({tag, " first_a"}, int'(a_first), e_first_a);
        chk({tag, " err_b"}, int'(b_err), e_err_b);
        chk({tag, " first_b"}, int'(b_first), e_first_b);
        chk({tag, " pass_a"}, int'(a_pass), e_pass_a);
        chk({tag, " pass_b"}, int'(b_pass), e_pass_b);
        chk({tag, " launch_pulses_a"}, va, 1);
        chk({tag, " launch_pulses_b"}, vb, 1);
        chk({tag, " rd_seen"}, rd, e_rd);
    endtask

    initial begin
        int ea, fa, eb, fb, d, lat, to;
        reset_n_i = 1'b0; start_i = 1'b0; dut_done_i = 1'b0;
        set_mode(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", int'(a_busy), 0);
        chk("rst done", int'(a_done), 0);
        chk("rst pass", int'(a_pass), 0);
        chk("rst valid", int'(a_dut_valid), 0);
        chk("rst rd_en", int'(a_rd_en), 0);
        chk("rst err", int'(a_err), 0);
        chk("rst timeout", int'(b_timeout), 0);
        @(negedge clk); reset_n_i = 1'b1;

        //          d  mode lat to ea fa eb fb pa pb rd
        tbl[0] = '{6,  0,  24, 0, 0, 0, 0, 0, 1, 1, 1};
        tbl[1] = '{3,  1,  21, 0, 2, 5, 2, 5, 0, 0, 1};
        tbl[2] = '{1,  2,  19, 0,16, 0, 1, 7, 0, 0, 1};
        tbl[3] = '{11, 0,  11, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{0,  0,  11, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{10, 0,  28, 0, 0, 0, 0, 0, 1, 1, 1};

        for (int i = 0; i < 6; i++) begin
            set_mode(tbl[i].mode);
            run_check($sformatf("vec%0d", i), tbl[i].d, -1, tbl[i].lat, tbl[i].to,
                      tbl[i].err_a, tbl[i].first_a, tbl[i].err_b, tbl[i].first_b,
                      tbl[i].pass_a, tbl[i].pass_b, tbl[i].rd);
            if (i == 1) begin
                // results hold in DONE; dut_done_i outside WAIT does nothing
                dut_done_i = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                dut_done_i = 1'b0;
                chk("hold done", int'(a_done), 1);
                chk("hold busy", int'(a_busy), 0);
                chk("hold valid", int'(a_dut_valid), 0);
                chk("hold err", int'(a_err), tbl[i].err_a);
                chk("hold first", int'(a_first), tbl[i].first_a);
            end
        end

        // Reset in the middle of SCAN, then a start plus an ignored start while busy.
        set_mode(1);
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0; dut_done_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        dut_done_i = 1'b0;
        chk("midscan rd_en", int'(a_rd_en), 1);
        reset_n_i = 1'b0;
        #1;
        chk("async rst busy", int'(a_busy), 0);
        chk("async rst rd_en", int'(a_rd_en), 0);
        chk("async rst done", int'(a_done), 0);
        chk("async rst valid", int'(b_dut_valid), 0);
        chk("async rst addr", int'(a_rd_addr), 0);
        @(negedge clk); reset_n_i = 1'b1;
        @(posedge clk); #1;
        chk("post rst idle busy", int'(a_busy), 0);
        chk("post rst idle valid", int'(a_dut_valid), 0);
        run_check("restart", 4, 2, 22, 0, 2, 5, 2, 5, 0, 0, 1);

        // Randomised runs against the reference model.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                gmem[i] = 16'($urandom);
                if ($urandom_range(0, 9) == 0) dmem[i] = 16'($urandom);
                else dmem[i] = 16'(int'(gmem[i]) + int'($urandom_range(0, 8)) - 4);
            end
            d = int'($urandom_range(0, 12));
            if (d == 0 || d > T) begin
                lat = T + 1; to = 1; ea = 0; fa = 0; eb = 0; fb = 0;
                run_check($sformatf("rnd%0d", r), d, -1, lat, to, ea, fa, eb, fb, 0, 0, 0);
            end else begin
                lat = d + N + 2; to = 0;
                model(0, ea, fa);
                model(2, eb, fb);
                run_check($sformatf("rnd%0d", r), d, -1, lat, to, ea, fa, eb, fb,
                          int'(ea == 0), int'(eb == 0), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cnn_run_checker
